// File: rtl/mul8s_arb_pkg.sv
// Shared types for the time-shared signed 8x8 multiplier arbiter.
// Used by mul8s_core and mul8s_share_arb.
package mul8s_arb_pkg;

    // Largest supported requester count and the id width that covers it.
    localparam int NREQ_MAX = 8;
    localparam int ID_W     = $clog2(NREQ_MAX);

    typedef logic signed [7:0]  op_t;
    typedef logic signed [15:0] prod_t;

    // One issued operation: both operands plus the requester that sent them.
    typedef struct packed {
        op_t             a;
        op_t             b;
        logic [ID_W-1:0] id;
    } mul_req_t;

endpackage

// File: rtl/mul8s_core.sv
// Exact combinational signed 8x8 -> 16 multiplier.
// Kept as its own module so approximate variants can be dropped in.
import mul8s_arb_pkg::*;

module mul8s_core (
    input  op_t   a_i,
    input  op_t   b_i,
    output prod_t p_o
);

    // Full-precision two's-complement product; no rounding or truncation.
    assign p_o = a_i * b_i;

endmodule

// File: rtl/mul8s_share_arb.sv
// Round-robin arbiter that time-shares one mul8s_core among NREQ requesters.
//
// Handshake: on both sides a transfer happens on a rising clock edge where
// valid and ready are both high. Requesters hold operands while valid and not
// yet granted; the response bus holds rsp_p/rsp_id while rsp_valid & !rsp_ready.
//
// Build option: define MUL8S_ARB_PIPE2_EN to add an operand register stage in
// front of the core (latency 2 instead of 1, throughput unchanged).
import mul8s_arb_pkg::*;

module mul8s_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_p,
    output logic [IDW-1:0]    rsp_id,
    output logic [CNTW-1:0]   op_count
);

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0] op_count_q, op_count_d;
    logic            rsp_valid_q;
    prod_t           rsp_p_q;
    logic [IDW-1:0]  rsp_id_q;

    logic            hold_out;     // output register blocked downstream
    logic            can_grant;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_idx;
    mul_req_t        cur_req;      // operands of the requester being granted
    mul_req_t        core_req;     // operands presented to the core
    logic            stage_valid;  // core_req holds a live operation
    prod_t           core_p;
    logic            id_unused;

    assign hold_out = rsp_valid_q & ~rsp_ready;

`ifdef MUL8S_ARB_PIPE2_EN
    logic     s1_valid_q;
    mul_req_t s1_q;
    logic     s1_hold;

    // Stage 1 may only be refilled when it is empty or about to move forward.
    assign s1_hold     = hold_out & s1_valid_q;
    assign can_grant   = ~rst & ~s1_hold;
    assign core_req    = s1_q;
    assign stage_valid = s1_valid_q;

    // Operand register stage; holds with the output when both are occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (!s1_hold) begin
            s1_valid_q <= gnt_any;
            if (gnt_any) begin
                s1_q <= cur_req;
            end
        end
    end
`else
    assign can_grant   = ~rst & ~hold_out;
    assign core_req    = cur_req;
    assign stage_valid = gnt_any;
`endif

    // Round-robin scan from the pointer upward; at most one one-hot grant.
    always_comb begin
        int j;
        j         = 0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        if (can_grant) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (int'(ptr_q) + k) % NREQ;
                if (!gnt_any && req_valid[j]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDW'(j);
                end
            end
        end
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        cur_req.a  = req_a[{gnt_idx, 3'b000} +: 8];
        cur_req.b  = req_b[{gnt_idx, 3'b000} +: 8];
        cur_req.id = ID_W'(gnt_idx);
    end

    // The package id field may be wider than this instance needs.
    assign id_unused = ^core_req.id;

    // Next pointer and saturating issue counter.
    always_comb begin
        ptr_d      = ptr_q;
        op_count_d = op_count_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (op_count_q != '1) begin
                op_count_d = op_count_q + 1'b1;
            end
        end
    end

    mul8s_core u_core (
        .a_i (core_req.a),
        .b_i (core_req.b),
        .p_o (core_p)
    );

    // Arbitration state: round-robin pointer and issue counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            op_count_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            op_count_q <= op_count_d;
        end
    end

    // Output register: loads whenever it is free or being accepted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_p_q     <= '0;
            rsp_id_q    <= '0;
        end else if (!hold_out) begin
            rsp_valid_q <= stage_valid;
            if (stage_valid) begin
                rsp_p_q  <= core_p;
                rsp_id_q <= core_req.id[IDW-1:0];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_mul8s_share_arb.sv
// Self-checking bench for mul8s_share_arb (NREQ=4). A second instance with
// CNTW=4 shares all inputs and is used for counter saturation.
// Define MUL8S_ARB_PIPE2_EN to check the two-stage build.
module tb_mul8s_share_arb;

`ifdef MUL8S_ARB_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_p;
  logic [1:0]  rsp_id;
  logic [15:0] op_count;

  logic [3:0]  d4_ready_unused;
  logic        d4_valid_unused;
  logic [15:0] d4_p_unused;
  logic [1:0]  d4_id_unused;
  logic [3:0]  op_count4;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  int          gnt_log[$];
  int          last_gnt = 0;

  mul8s_share_arb #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .rsp_id(rsp_id), .op_count(op_count)
  );

  mul8s_share_arb #(.NREQ(4), .IDW(2), .CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(d4_ready_unused), .rsp_valid(d4_valid_unused), .rsp_ready(rsp_ready),
    .rsp_p(d4_p_unused), .rsp_id(d4_id_unused), .op_count(op_count4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mulref(logic [7:0] a, logic [7:0] b);
    logic signed [15:0] r;
    r = $signed(a) * $signed(b);
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [17:0] e;
    logic [3:0]  g;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d p=%h, required no response", rsp_id, rsp_p);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_id, rsp_p} !== e) begin
            errors++;
            $display("FAIL rsp_data: got id=%0d p=%h, required id=%0d p=%h",
                     rsp_id, rsp_p, e[17:16], e[15:0]);
          end
        end
      end
      g = req_valid & req_ready;
      if (g != 4'b0) begin
        checks++;
        if ($countones(g) != 1) begin
          errors++;
          $display("FAIL grant_onehot: got %b, required one bit", g);
        end
        for (int i = 0; i < 4; i++) begin
          if (g[i]) begin
            exp_q.push_back({2'(i), mulref(req_a[i*8 +: 8], req_b[i*8 +: 8])});
            gnt_log.push_back(i);
            last_gnt = i;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One cycle of continuous traffic: granted requesters present fresh operands.
  task automatic cycle_update();
    logic [3:0] g;
    @(negedge clk);
    g = req_valid & req_ready;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) set_op(i, 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 30 && !done; c++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !rsp_valid) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: got %0d outstanding, rsp_valid=%b, required 0 and 0",
               name, exp_q.size(), rsp_valid);
    end
  endtask

  // Issue one op from requester i and check grant, latency and result.
  task automatic issue_single(input int i, input logic [7:0] a, input logic [7:0] b,
                              input logic [15:0] exp_p, input string name);
    logic [3:0] exp_rdy;
    exp_rdy = 4'b0;
    exp_rdy[i] = 1'b1;
    @(posedge clk); #1;
    set_op(i, a, b);
    req_valid = exp_rdy;
    @(negedge clk);
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL %s_grant: got %b, required %b", name, req_ready, exp_rdy);
    end
    @(posedge clk); #1;
    req_valid = 4'b0;
    repeat (LAT - 1) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_early: got rsp_valid=%b, required 0", name, rsp_valid);
      end
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== exp_p || rsp_id !== 2'(i)) begin
      errors++;
      $display("FAIL %s_rsp: got v=%b p=%h id=%0d, required v=1 p=%h id=%0d",
               name, rsp_valid, rsp_p, rsp_id, exp_p, i);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    req_valid = 4'b1010;
    set_op(1, 8'd3, 8'd5);
    set_op(3, 8'd2, 8'd2);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_p !== 16'h0 || rsp_id !== 2'd0 || op_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: got v=%b p=%h id=%0d cnt=%0d, required 0 0 0 0",
               rsp_valid, rsp_p, rsp_id, op_count);
    end
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL reset_ptr: got %b, required 0010", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 4'b0;
    drain("reset");
  endtask

  task automatic test_single();
    do_reset();
    issue_single(0, 8'h80, 8'h80, 16'h4000, "t1_neg_neg");
    issue_single(1, 8'h80, 8'h7f, 16'hC080, "t2_neg_pos");
    issue_single(1, 8'h07, 8'hff, 16'hFFF9, "t2_small");
    drain("single");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'($urandom), 8'($urandom));
    gnt_log.delete();
    req_valid = 4'b1111;
    repeat (8) cycle_update();
    req_valid = 4'b0;
    @(negedge clk);
    checks++;
    if (op_count !== 16'd8) begin
      errors++;
      $display("FAIL rr_count: got %0d, required 8", op_count);
    end
    checks++;
    if (gnt_log.size() != 8) begin
      errors++;
      $display("FAIL rr_len: got %0d grants, required 8", gnt_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (gnt_log[k] != k % 4) begin
          errors++;
          $display("FAIL rr_order: grant %0d got id %0d, required %0d", k, gnt_log[k], k % 4);
        end
      end
    end
    drain("rr");
  endtask

  task automatic test_backpressure();
    logic [15:0] hp;
    logic [1:0]  hid;
    int          lg;
    logic [3:0]  exp_rdy;
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'($urandom), 8'($urandom));
    req_valid = 4'b1111;
    repeat (5) cycle_update();
    rsp_ready = 1'b0;
    @(negedge clk);
    hp  = rsp_p;
    hid = rsp_id;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid: got %b, required 1", rsp_valid);
    end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (rsp_p !== hp || rsp_id !== hid || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got p=%h id=%0d rdy=%b, required p=%h id=%0d rdy=0000",
                 c, rsp_p, rsp_id, req_ready, hp, hid);
      end
      @(posedge clk); #1;
    end
    lg = last_gnt;
    rsp_ready = 1'b1;
    exp_rdy = 4'b0;
    exp_rdy[(lg + 1) % 4] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL bp_resume: got %b, required %b", req_ready, exp_rdy);
    end
    repeat (4) cycle_update();
    drain("bp");
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_op(0, 8'd9, 8'd9);
    set_op(2, 8'd4, 8'hfe);
    set_op(3, 8'd1, 8'd1);
    req_valid = 4'b0001;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 4'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b1100;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_state: got v=%b cnt=%0d, required 0 0", rsp_valid, op_count);
    end
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_grant: got %b, required 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 4'b0;
    drain("midrst");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'($urandom), 8'($urandom));
    req_valid = 4'b1111;
    repeat (20) cycle_update();
    req_valid = 4'b0;
    @(negedge clk);
    checks++;
    if (op_count4 !== 4'd15) begin
      errors++;
      $display("FAIL sat_cnt4: got %0d, required 15", op_count4);
    end
    checks++;
    if (op_count !== 16'd20) begin
      errors++;
      $display("FAIL sat_cnt16: got %0d, required 20", op_count);
    end
    drain("sat");
  endtask

  task automatic test_random();
    logic [3:0] g;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (g[i] || !req_valid[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_op(i, 8'($urandom), 8'($urandom));
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain("rand");
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'b0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
